// File: rtl/efpga_exec_unit_pkg.sv
// Shared eFPGA custom-instruction decode constants, FSM state encoding and
// timeout counter width used by the execution unit and its helpers.
package efpga_exec_unit_pkg;

    localparam logic [6:0] EFPGA_OPCODE  = 7'b1110011;
    localparam logic [2:0] EFPGA_F3_SEL0 = 3'b110;
    localparam logic [2:0] EFPGA_F3_SEL1 = 3'b111;

    // Wide enough for the largest supported timeout (65535 cycles).
    localparam int TIMEOUT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } exec_state_e;

    function automatic logic is_efpga_instr(input logic [31:0] instr);
        return (instr[6:0] == EFPGA_OPCODE) &&
               ((instr[14:12] == EFPGA_F3_SEL0) || (instr[14:12] == EFPGA_F3_SEL1));
    endfunction

endpackage

// File: rtl/efpga_timeout_cnt.sv
// Issue-to-response watchdog: cleared by load, counts while enabled and
// flags expiry once it has reached LIMIT-1.
module efpga_timeout_cnt
    import efpga_exec_unit_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic srst_n,
    input  logic load,
    input  logic enable,
    output logic expire
);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    assign expire = (cnt_q == TIMEOUT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable && !expire) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/efpga_exec_unit.sv
// Pipeline execution unit that forwards custom eFPGA instructions to the
// fabric, waits (bounded) for the result and writes it back to the register file.
module efpga_exec_unit
    import efpga_exec_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            p_clk,
    input  logic            p_reset,
    input  logic            p_instr_valid,
    input  logic [31:0]     p_instr,
    input  logic [XLEN-1:0] p_rs1_data,
    input  logic [XLEN-1:0] p_rs2_data,
    input  logic            p_flush,
    output logic            p_busy,
    output logic            p_efpga_req_valid,
    input  logic            p_efpga_req_ready,
    output logic            p_efpga_sel,
    output logic [6:0]      p_efpga_funct7,
    output logic [XLEN-1:0] p_efpga_op_a,
    output logic [XLEN-1:0] p_efpga_op_b,
    input  logic            p_efpga_rsp_valid,
    input  logic [XLEN-1:0] p_efpga_rsp_data,
    output logic            p_wb_valid,
    output logic [4:0]      p_wb_rd,
    output logic [XLEN-1:0] p_wb_data,
    output logic            p_err
);

    exec_state_e     state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic            sel_q, sel_d;
    logic [6:0]      funct7_q, funct7_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic            busy_q, busy_d;
    logic            req_valid_q, req_valid_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            err_q, err_d;

    logic            cnt_load;
    logic            cnt_en;
    logic            cnt_expire;
    logic            done_err;
    logic [XLEN-1:0] done_data;
    logic            unused_instr_bits;

    assign unused_instr_bits = ^p_instr[24:15];

    efpga_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (p_clk),
        .srst_n (p_reset),
        .load   (cnt_load),
        .enable (cnt_en),
        .expire (cnt_expire)
    );

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        sel_d     = sel_q;
        funct7_d  = funct7_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        done_err  = 1'b0;
        done_data = '0;

        unique case (state_q)
            S_IDLE: begin
                if (p_instr_valid && is_efpga_instr(p_instr)) begin
                    state_d  = S_ISSUE;
                    rd_d     = p_instr[11:7];
                    funct7_d = p_instr[31:25];
                    sel_d    = p_instr[12];
                    op_a_d   = p_rs1_data;
                    op_b_d   = p_rs2_data;
                    cnt_load = 1'b1;
                end
            end
            // A handshake in the expiry cycle still counts: the fabric owns the op.
            S_ISSUE: begin
                if (p_efpga_req_ready) begin
                    state_d  = S_WAIT;
                    cnt_load = 1'b1;
                end else if (cnt_expire) begin
                    state_d  = S_DONE;
                    done_err = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_WAIT: begin
                if (p_efpga_rsp_valid) begin
                    state_d   = S_DONE;
                    done_data = p_efpga_rsp_data;
                end else if (cnt_expire) begin
                    state_d  = S_DONE;
                    done_err = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (p_flush) begin
            state_d = S_IDLE;
        end

        // Result registers change only on completion so they stay readable afterwards.
        if (state_d == S_DONE) begin
            wb_rd_d   = rd_q;
            wb_data_d = done_data;
        end

        busy_d      = (state_d != S_IDLE);
        req_valid_d = (state_d == S_ISSUE);
        wb_valid_d  = (state_d == S_DONE) && (rd_q != 5'd0);
        err_d       = (state_d == S_DONE) && done_err;
    end

    always_ff @(posedge p_clk) begin
        if (!p_reset) begin
            state_q     <= S_IDLE;
            rd_q        <= '0;
            sel_q       <= 1'b0;
            funct7_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            busy_q      <= 1'b0;
            req_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            sel_q       <= sel_d;
            funct7_q    <= funct7_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            busy_q      <= busy_d;
            req_valid_q <= req_valid_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
        end
    end

    assign p_busy            = busy_q;
    assign p_efpga_req_valid = req_valid_q;
    assign p_efpga_sel       = sel_q;
    assign p_efpga_funct7    = funct7_q;
    assign p_efpga_op_a      = op_a_q;
    assign p_efpga_op_b      = op_b_q;
    assign p_wb_valid        = wb_valid_q;
    assign p_wb_rd           = wb_rd_q;
    assign p_wb_data         = wb_data_q;
    assign p_err             = err_q;

endmodule

// File: tb/tb_efpga_exec_unit.sv
// Scoreboard bench for efpga_exec_unit: a driver models the fabric and queues
// expected write-backs; a negedge monitor compares every strobe it sees.
module tb_efpga_exec_unit;

    localparam int XLEN  = 32;
    localparam int TC    = 16;
    localparam int NEVER = 1000;

    logic            p_clk;
    logic            p_reset;
    logic            p_instr_valid;
    logic [31:0]     p_instr;
    logic [XLEN-1:0] p_rs1_data;
    logic [XLEN-1:0] p_rs2_data;
    logic            p_flush;
    logic            p_busy;
    logic            p_efpga_req_valid;
    logic            p_efpga_req_ready;
    logic            p_efpga_sel;
    logic [6:0]      p_efpga_funct7;
    logic [XLEN-1:0] p_efpga_op_a;
    logic [XLEN-1:0] p_efpga_op_b;
    logic            p_efpga_rsp_valid;
    logic [XLEN-1:0] p_efpga_rsp_data;
    logic            p_wb_valid;
    logic [4:0]      p_wb_rd;
    logic [XLEN-1:0] p_wb_data;
    logic            p_err;

    efpga_exec_unit #(
        .XLEN           (XLEN),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .p_clk             (p_clk),
        .p_reset           (p_reset),
        .p_instr_valid     (p_instr_valid),
        .p_instr           (p_instr),
        .p_rs1_data        (p_rs1_data),
        .p_rs2_data        (p_rs2_data),
        .p_flush           (p_flush),
        .p_busy            (p_busy),
        .p_efpga_req_valid (p_efpga_req_valid),
        .p_efpga_req_ready (p_efpga_req_ready),
        .p_efpga_sel       (p_efpga_sel),
        .p_efpga_funct7    (p_efpga_funct7),
        .p_efpga_op_a      (p_efpga_op_a),
        .p_efpga_op_b      (p_efpga_op_b),
        .p_efpga_rsp_valid (p_efpga_rsp_valid),
        .p_efpga_rsp_data  (p_efpga_rsp_data),
        .p_wb_valid        (p_wb_valid),
        .p_wb_rd           (p_wb_rd),
        .p_wb_data         (p_wb_data),
        .p_err             (p_err)
    );

    typedef struct {
        logic            wb;
        logic            err;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;
    always @(posedge p_clk) cyc <= cyc + 1;

    // Fabric behaviour: sel=0 adds, sel=1 xors and adds funct7.
    function automatic logic [XLEN-1:0] fab(input logic sel, input logic [6:0] f7,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return sel ? ((a ^ b) + XLEN'(f7)) : (a + b);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},      p_busy, 0);
        chk({tag, "_req_valid"}, p_efpga_req_valid, 0);
        chk({tag, "_sel"},       p_efpga_sel, 0);
        chk({tag, "_funct7"},    p_efpga_funct7, 0);
        chk({tag, "_op_a"},      p_efpga_op_a, 0);
        chk({tag, "_op_b"},      p_efpga_op_b, 0);
        chk({tag, "_wb_valid"},  p_wb_valid, 0);
        chk({tag, "_wb_rd"},     p_wb_rd, 0);
        chk({tag, "_wb_data"},   p_wb_data, 0);
        chk({tag, "_err"},       p_err, 0);
    endtask

    always @(negedge p_clk) begin
        if (p_wb_valid || p_err) begin
            $display("strobe: cyc=%0d wb_valid=%0b rd=%0d data=%h err=%0b",
                     cyc, p_wb_valid, p_wb_rd, p_wb_data, p_err);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {p_wb_valid, p_err}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_valid", p_wb_valid, mon_e.wb);
                chk("err", p_err, mon_e.err);
                chk("strobe_cycle", cyc, mon_e.cyc);
                if (mon_e.wb) begin
                    chk("wb_rd", p_wb_rd, mon_e.rd);
                    chk("wb_data", p_wb_data, mon_e.data);
                end
            end
        end
    end

    // One instruction through the unit. Delays are in cycles; rsp_dly >= TC never
    // answers in time; flush_at >= 0 flushes during WAIT and sends a late response.
    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [6:0] f7, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input int rdy_dly, input int rsp_dly, input int flush_at, input bit spur);
        bit   match;
        bit   sel;
        exp_t e;
        int   k;
        int   j;
        match = (opc == 7'b1110011) && ((f3 == 3'b110) || (f3 == 3'b111));
        sel   = f3[0];
        p_instr       = {f7, 5'($urandom), 5'($urandom), f3, rd, opc};
        p_rs1_data    = a;
        p_rs2_data    = b;
        p_instr_valid = 1'b1;
        @(negedge p_clk);
        p_instr_valid = 1'b0;
        p_instr       = $urandom;
        p_rs1_data    = $urandom;
        p_rs2_data    = $urandom;
        if (!match) begin
            chk("nomatch_busy", p_busy, 0);
            chk("nomatch_req_valid", p_efpga_req_valid, 0);
            return;
        end
        k = 0;
        forever begin
            chk("issue_req_valid", p_efpga_req_valid, 1);
            chk("issue_busy", p_busy, 1);
            chk("issue_sel", p_efpga_sel, sel);
            chk("issue_funct7", p_efpga_funct7, f7);
            chk("issue_op_a", p_efpga_op_a, a);
            chk("issue_op_b", p_efpga_op_b, b);
            p_efpga_rsp_valid = spur;
            p_efpga_rsp_data  = 32'hDEAD_BEEF;
            if (k == rdy_dly) break;
            k++;
            @(negedge p_clk);
        end
        p_efpga_req_ready = 1'b1;
        if (flush_at < 0) begin
            e.rd = rd;
            if (rsp_dly <= TC - 1) begin
                e.err  = 1'b0;
                e.data = fab(sel, f7, a, b);
                e.cyc  = cyc + 2 + rsp_dly;
            end else begin
                e.err  = 1'b1;
                e.data = '0;
                e.cyc  = cyc + 1 + TC;
            end
            e.wb = (rd != 5'd0);
            if (e.wb || e.err) exp_q.push_back(e);
        end
        @(negedge p_clk);
        p_efpga_req_ready = 1'b0;
        p_efpga_rsp_valid = 1'b0;
        chk("wait_req_dropped", p_efpga_req_valid, 0);
        for (j = 0; (j < 100) && p_busy; j++) begin
            if (j == flush_at) begin
                p_flush = 1'b1;
            end else if (j == rsp_dly) begin
                p_efpga_rsp_valid = 1'b1;
                p_efpga_rsp_data  = fab(p_efpga_sel, p_efpga_funct7, p_efpga_op_a, p_efpga_op_b);
            end
            @(negedge p_clk);
            p_flush           = 1'b0;
            p_efpga_rsp_valid = 1'b0;
        end
        chk("op_returns_idle", p_busy, 0);
        if (flush_at >= 0) begin
            p_efpga_rsp_valid = 1'b1;
            p_efpga_rsp_data  = 32'h1234_5678;
            @(negedge p_clk);
            p_efpga_rsp_valid = 1'b0;
            chk("late_rsp_busy", p_busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] opc;
        logic [2:0] f3;
        int         fl;
        int         rs;

        p_reset           = 1'b0;
        p_instr_valid     = 1'b0;
        p_instr           = '0;
        p_rs1_data        = '0;
        p_rs2_data        = '0;
        p_flush           = 1'b0;
        p_efpga_req_ready = 1'b0;
        p_efpga_rsp_valid = 1'b0;
        p_efpga_rsp_data  = '0;
        repeat (3) @(negedge p_clk);
        chk_zero("reset");
        p_reset = 1'b1;
        @(negedge p_clk);

        // Minimum-latency add, then delayed handshake with spurious early responses.
        run_op(7'b1110011, 3'b110, 5'd5, 7'd0, 32'd3, 32'd4, 0, 0, -1, 1'b0);
        run_op(7'b1110011, 3'b111, 5'd9, 7'h2a, 32'hCAFE_0001, 32'h0F0F_1234, 3, 9, -1, 1'b1);
        // Timeout, response exactly at the timeout cycle, and one cycle too late.
        run_op(7'b1110011, 3'b110, 5'd7, 7'h05, 32'h11, 32'h22, 0, NEVER, -1, 1'b0);
        run_op(7'b1110011, 3'b111, 5'd8, 7'h01, 32'h55, 32'h66, 1, TC - 1, -1, 1'b0);
        run_op(7'b1110011, 3'b110, 5'd10, 7'h00, 32'h77, 32'h88, 0, TC, -1, 1'b0);
        // Flush in WAIT with a late response, then a normal op.
        run_op(7'b1110011, 3'b111, 5'd12, 7'h33, 32'hAAAA, 32'h5555, 1, 4, 2, 1'b0);
        run_op(7'b1110011, 3'b110, 5'd13, 7'h00, 32'h100, 32'h200, 0, 1, -1, 1'b0);
        // rd=0 (no write-back), rd=0 timeout (error only), non-matching encodings.
        run_op(7'b1110011, 3'b110, 5'd0, 7'h00, 32'h1, 32'h2, 0, 2, -1, 1'b0);
        run_op(7'b1110011, 3'b111, 5'd0, 7'h00, 32'h1, 32'h2, 0, NEVER, -1, 1'b0);
        run_op(7'b1110011, 3'b001, 5'd4, 7'h00, 32'h1, 32'h2, 0, 0, -1, 1'b0);
        run_op(7'b0110011, 3'b110, 5'd4, 7'h00, 32'h1, 32'h2, 0, 0, -1, 1'b0);

        // Flush wins over acceptance in IDLE.
        p_instr       = {7'h00, 10'h0, 3'b110, 5'd6, 7'b1110011};
        p_instr_valid = 1'b1;
        p_flush       = 1'b1;
        @(negedge p_clk);
        p_instr_valid = 1'b0;
        p_flush       = 1'b0;
        chk("idle_flush_busy", p_busy, 0);
        chk("idle_flush_req_valid", p_efpga_req_valid, 0);

        // Reset while the request is pending.
        p_instr       = {7'h11, 10'h0, 3'b111, 5'd3, 7'b1110011};
        p_rs1_data    = 32'h1357;
        p_rs2_data    = 32'h2468;
        p_instr_valid = 1'b1;
        @(negedge p_clk);
        p_instr_valid = 1'b0;
        chk("pre_reset_req_valid", p_efpga_req_valid, 1);
        p_reset = 1'b0;
        @(negedge p_clk);
        chk_zero("reset_in_issue");
        p_reset = 1'b1;
        @(negedge p_clk);
        chk("post_reset_busy", p_busy, 0);

        for (int n = 0; n < 40; n++) begin
            opc = ($urandom_range(0, 9) == 0) ? 7'b0110011 : 7'b1110011;
            case ($urandom_range(0, 4))
                0, 1:    f3 = 3'b110;
                2, 3:    f3 = 3'b111;
                default: f3 = 3'($urandom);
            endcase
            fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
            if (fl >= 0) rs = fl + int'($urandom_range(1, 3));
            else if ($urandom_range(0, 4) == 0) rs = NEVER;
            else rs = int'($urandom_range(0, 17));
            run_op(opc, f3, 5'($urandom), 7'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, 4)), rs, fl, 1'($urandom));
        end

        repeat (5) @(negedge p_clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
